// File: rtl/uart_xmit.sv
// UART transmitter: one-byte holding register in front of a shift register,
// framed LSB-first as start, data, optional parity, one stop bit.
module uart_xmit #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 rdy,
  output logic                 txd,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_xmit: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bits_check
    $error("uart_xmit: DATA_BITS must be 5..8");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 r_state;
  logic [DATA_BITS-1:0]   r_hold;
  logic                   r_hold_full;
  logic [DATA_BITS-1:0]   r_shreg;
  logic [2:0]             r_bit_cnt;
  logic [CW-1:0]          r_baud_cnt;
  logic                   r_parity;
  logic                   r_txd;

  state_t                 w_state_nxt;
  logic [DATA_BITS-1:0]   w_shreg_nxt;
  logic [2:0]             w_bit_cnt_nxt;
  logic                   w_txd_nxt;
  logic                   w_load;
  logic                   w_tick;
  logic                   w_accept;

  // Handshake: the host may offer data at any time; a byte is taken on a
  // clk edge where valid && rdy, and rdy is simply "holding register empty".
  assign rdy       = ~r_hold_full;
  assign w_accept  = valid & ~r_hold_full;
  assign w_tick    = (r_baud_cnt == LAST_CNT);
  assign txd       = r_txd;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_txd_nxt     = r_txd;
    w_load        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_hold_full) begin
          w_load      = 1'b1;
          w_txd_nxt   = 1'b0;
          w_state_nxt = S_START;
        end else begin
          w_txd_nxt = 1'b1;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_txd_nxt     = r_shreg[0];
          w_bit_cnt_nxt = 3'd0;
          w_state_nxt   = S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              w_txd_nxt   = r_parity;
              w_state_nxt = S_PARITY;
            end else begin
              w_txd_nxt   = 1'b1;
              w_state_nxt = S_STOP;
            end
          end else begin
            w_shreg_nxt   = r_shreg >> 1;
            w_txd_nxt     = r_shreg[1];
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_txd_nxt   = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          // A held byte starts immediately so back-to-back frames have no gap.
          if (r_hold_full) begin
            w_load      = 1'b1;
            w_txd_nxt   = 1'b0;
            w_state_nxt = S_START;
          end else begin
            w_txd_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_txd_nxt   = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_load) w_shreg_nxt = r_hold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shreg     <= '0;
      r_bit_cnt   <= 3'd0;
      r_baud_cnt  <= '0;
      r_parity    <= 1'b0;
      r_txd       <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_txd     <= w_txd_nxt;
      if (r_state == S_IDLE || w_load || w_tick) r_baud_cnt <= '0;
      else                                       r_baud_cnt <= r_baud_cnt + 1'b1;
      if (w_accept) begin
        r_hold      <= data;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
      // Parity is taken from the whole byte as it is loaded.
      if (w_load) r_parity <= (^r_hold) ^ (PARITY_ODD != 0);
    end
  end

endmodule

// File: tb/tb_uart_xmit.sv
// Directed bench for uart_xmit: four instances (8N, 8E, 8O, 5N) at DIV=10,
// every line sample checked against hand-specified frames.
module tb_uart_xmit;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din8 [3];
  logic [4:0] din5;
  logic       vin    [4];
  logic       rdy_w  [4];
  logic       txd_w  [4];
  logic       busy_w [4];
  logic [2:0] st_w   [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_xmit #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
              .PARITY_EN(0), .PARITY_ODD(0)) u_8n (
    .clk(clk), .rst(rst), .data(din8[0]), .valid(vin[0]), .rdy(rdy_w[0]),
    .txd(txd_w[0]), .busy(busy_w[0]), .dbg_state(st_w[0]));

  uart_xmit #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
              .PARITY_EN(1), .PARITY_ODD(0)) u_8e (
    .clk(clk), .rst(rst), .data(din8[1]), .valid(vin[1]), .rdy(rdy_w[1]),
    .txd(txd_w[1]), .busy(busy_w[1]), .dbg_state(st_w[1]));

  uart_xmit #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
              .PARITY_EN(1), .PARITY_ODD(1)) u_8o (
    .clk(clk), .rst(rst), .data(din8[2]), .valid(vin[2]), .rdy(rdy_w[2]),
    .txd(txd_w[2]), .busy(busy_w[2]), .dbg_state(st_w[2]));

  uart_xmit #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(5),
              .PARITY_EN(0), .PARITY_ODD(0)) u_5n (
    .clk(clk), .rst(rst), .data(din5), .valid(vin[3]), .rdy(rdy_w[3]),
    .txd(txd_w[3]), .busy(busy_w[3]), .dbg_state(st_w[3]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int k, input logic v, input logic [7:0] d);
    vin[k] = v;
    if (k == 3) din5 = d[4:0];
    else        din8[k] = d;
  endtask

  // Frame bit list, index 0 = start bit; unused upper positions stay 1.
  function automatic logic [11:0] mk_frame(input logic [7:0] d, input int nd,
                                           input bit pe, input logic p);
    logic [11:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < nd; i++) f[1 + i] = d[i];
    if (pe) f[1 + nd] = p;
    return f;
  endfunction

  // Accept edge: afterwards the byte is held but the FSM has not loaded yet.
  task automatic send(input int k, input logic [7:0] d);
    set_in(k, 1'b1, d);
    step();
    set_in(k, 1'b0, 8'h00);
    chk($sformatf("accept rdy k%0d", k), rdy_w[k], 1'b0);
    chk($sformatf("accept busy k%0d", k), busy_w[k], 1'b0);
  endtask

  // Checks every sample of a frame; optionally offers a second byte at sample
  // inj_at, then floods valid with 0xFF for 'flood' cycles.
  task automatic run_frame(input int k, input string name, input logic [11:0] bits,
                           input int nb, input int inj_at, input logic [7:0] inj_d,
                           input int flood, input int stop_at);
    for (int s = 1; s <= nb * DIV && s <= stop_at; s++) begin
      step();
      chk($sformatf("%s txd s%0d", name, s), txd_w[k], bits[(s - 1) / DIV]);
      chk($sformatf("%s busy s%0d", name, s), busy_w[k], 1'b1);
      chk($sformatf("%s rdy s%0d", name, s), rdy_w[k],
          (inj_at > 0 && s > inj_at) ? 1'b0 : 1'b1);
      if (inj_at > 0) begin
        if (s == inj_at) set_in(k, 1'b1, inj_d);
        else if (s == inj_at + 1) begin
          if (flood > 0) set_in(k, 1'b1, 8'hFF);
          else           set_in(k, 1'b0, 8'h00);
        end else if (flood > 0 && s == inj_at + 1 + flood) set_in(k, 1'b0, 8'h00);
      end
    end
  endtask

  task automatic idle_check(input int k, input string name, input int n);
    for (int s = 1; s <= n; s++) begin
      step();
      chk($sformatf("%s txd s%0d", name, s), txd_w[k], 1'b1);
      chk($sformatf("%s busy s%0d", name, s), busy_w[k], 1'b0);
      chk($sformatf("%s rdy s%0d", name, s), rdy_w[k], 1'b1);
    end
    chk3($sformatf("%s state", name), st_w[k], 3'd0);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 4; k++) set_in(k, 1'b0, 8'h00);
    repeat (3) step();

    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset txd k%0d", k), txd_w[k], 1'b1);
      chk($sformatf("reset rdy k%0d", k), rdy_w[k], 1'b1);
      chk($sformatf("reset busy k%0d", k), busy_w[k], 1'b0);
      chk3($sformatf("reset state k%0d", k), st_w[k], 3'd0);
    end
    rst = 1'b0;
    idle_check(0, "post_reset", 5);

    // Single 0x55 frame, 100 cycles, then idle.
    send(0, 8'h55);
    run_frame(0, "f55", mk_frame(8'h55, 8, 1'b0, 1'b0), 10, 0, 8'h00, 0, 1000);
    idle_check(0, "post55", 5);

    // Back-to-back 0xA5 then 0x3C, with 0xFF pressed on a full holding register.
    send(0, 8'hA5);
    run_frame(0, "fA5", mk_frame(8'hA5, 8, 1'b0, 1'b0), 10, 5, 8'h3C, 50, 1000);
    run_frame(0, "f3C", mk_frame(8'h3C, 8, 1'b0, 1'b0), 10, 0, 8'h00, 0, 1000);
    idle_check(0, "post3C", 30);

    // Parity frames, 110 cycles each.
    send(1, 8'h07);
    run_frame(1, "pe07", mk_frame(8'h07, 8, 1'b1, 1'b1), 11, 0, 8'h00, 0, 1000);
    idle_check(1, "post_pe07", 3);
    send(2, 8'h07);
    run_frame(2, "po07", mk_frame(8'h07, 8, 1'b1, 1'b0), 11, 0, 8'h00, 0, 1000);
    idle_check(2, "post_po07", 3);
    send(1, 8'h00);
    run_frame(1, "pe00", mk_frame(8'h00, 8, 1'b1, 1'b0), 11, 0, 8'h00, 0, 1000);
    idle_check(1, "post_pe00", 3);

    // Five data bits: 70-cycle frame.
    send(3, 8'h1F);
    run_frame(3, "f5b1F", mk_frame(8'h1F, 5, 1'b0, 1'b0), 7, 0, 8'h00, 0, 1000);
    idle_check(3, "post5b", 3);

    // Reset on cycle 45 of a 0x55 frame with 0x99 held.
    send(0, 8'h55);
    run_frame(0, "r55", mk_frame(8'h55, 8, 1'b0, 1'b0), 10, 5, 8'h99, 0, 44);
    rst = 1'b1;
    step();
    chk("midrst txd", txd_w[0], 1'b1);
    chk("midrst busy", busy_w[0], 1'b0);
    chk("midrst rdy", rdy_w[0], 1'b1);
    chk3("midrst state", st_w[0], 3'd0);
    rst = 1'b0;
    idle_check(0, "post_midrst", 150);
    send(0, 8'h81);
    run_frame(0, "f81", mk_frame(8'h81, 8, 1'b0, 1'b0), 10, 0, 8'h00, 0, 1000);
    idle_check(0, "post81", 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_xmit.md
Name: uart_xmit

Overview:
UART transmitter. It is the transmit-side companion to the lab's 16x-oversampled UART receiver and drives the serial line that the receiver samples. A host presents parallel bytes through a valid/rdy handshake. The block buffers one byte in a holding register while another shifts out, and serializes frames LSB-first as: start, data, optional parity, one stop bit.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate in bits/s; bit period DIV = CLK_FREQ/BAUD_RATE clk cycles (integer divide, DIV >= 2 required, elaboration error otherwise)
DATA_BITS, 8, data bits per frame (5..8)
PARITY_EN, 0, 1 = insert parity bit after data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN = 0)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
data  input  DATA_BITS  byte to transmit, sampled on accept
valid  input  1  host offers data
rdy  output  1  holding register empty; accept occurs on a clk edge with valid && rdy
txd  output  1  serial line, registered, idle high
busy  output  1  frame in progress (state != IDLE)

Behaviour:
- Reset (rst high at edge): state IDLE, txd = 1, hold_full = 0 (rdy = 1), busy = 0, baud counter = 0, bit counter = 0, shift register = 0. Takes priority over all other events. Mid-frame reset abandons the frame: txd returns high on that same edge. The held byte is discarded and nothing resumes.
- Holding register:
  - rdy = ~hold_full (combinational).
  - On an accept edge, data is captured and hold_full is set.
  - valid while rdy = 0 is ignored; no capture and no error.
  - hold_full clears on the edge where the byte is moved to the shift register.
  - Accept and transfer never coincide, because transfer requires hold_full = 1, which forces rdy = 0.
- Baud counter:
  - Counts 0..DIV-1 while busy; tick = (count == DIV-1).
  - Forced to 0 on every load edge so each bit lasts exactly DIV cycles.
  - Held at 0 in IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if hold_full, load shift register from holding register, clear hold_full, txd <= 0, go to START. Otherwise txd <= 1.
  - START: on tick, txd <= shreg[0], bit counter <= 0, go to DATA.
  - DATA: on tick:
    - If bit counter == DATA_BITS-1: go to PARITY with txd <= parity when PARITY_EN, else go to STOP with txd <= 1.
    - Otherwise: shift right, txd <= next bit, increment bit counter.
  - PARITY: parity = XOR of the loaded byte, inverted when PARITY_ODD. On tick, txd <= 1, go to STOP.
  - STOP: on tick, if hold_full, load and txd <= 0 and go to START (back-to-back, zero idle gap). Otherwise go to IDLE with txd = 1.
- Latency: for an accept at edge E, txd falls at edge E+1 when the FSM was IDLE.
- Frame length: (2 + DATA_BITS + PARITY_EN) * DIV cycles.
- Parity is computed on the full byte at load, not on the shifted remainder.
- busy goes high on the load edge and low on the STOP-to-IDLE edge.

Test Plan:
- Single byte, CLK_FREQ=1_000_000, BAUD_RATE=100_000 (DIV=10), no parity, send 0x55 -> txd = 0 for cycles 1-10, then 1,0,1,0,1,0,1,0 for 10 cycles each, then 1 for 10 cycles. busy high for exactly 100 cycles, then IDLE, and rdy high again the cycle after accept.
- Back-to-back: accept 0xA5, then accept 0x3C at cycle 5 of its frame -> rdy low from then until the second load at cycle 100. The second start bit begins immediately at cycle 100, both frames are bit-exact, and busy stays high for 200 cycles.
- Holding full: while 0x3C is held and 0xA5 is shifting, assert valid with 0xFF for 50 cycles -> no capture, rdy = 0 throughout, and 0xFF is never transmitted.
- Parity, DIV=10: PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1, frame 110 cycles. PARITY_ODD=1, send 0x07 -> parity bit 0. PARITY_EN=1, PARITY_ODD=0, send 0x00 -> parity bit 0.
- Mid-frame reset: assert rst at cycle 45 of a 0x55 frame with a byte held -> after that edge txd = 1, busy = 0, rdy = 1, and no further line activity. A new 0x81 sent afterwards transmits a clean full frame.
- Bit timing: with DIV=10 and DATA_BITS=5, send 0x1F -> every txd level run is a multiple of 10 cycles, and the frame is 70 cycles.
